// File: rtl/layer_select_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// layer_select_ctrl_pkg
// Shared definitions for the 7-layer output multiplexer controller.
//   NUM_LAYERS    : layer count, equal to the mux width
//   LAYER_PLAYER  : index of the player layer (highest priority)
//   SEL_NONE      : active-low select value meaning "no layer"
//   flash_state_e : player hit-flash sequence states
//   layer_bit()   : one-hot vector with a single layer bit set
// ----------------------------------------------------------------------------
package layer_select_ctrl_pkg;

    localparam int unsigned NUM_LAYERS   = 7;
    localparam int unsigned LAYER_PLAYER = 0;

    localparam logic [NUM_LAYERS-1:0] SEL_NONE   = 7'b111_1111;
    localparam logic [NUM_LAYERS-1:0] MASK_ALL   = 7'h7F;
    localparam logic [NUM_LAYERS-1:0] PLAYER_BIT = 7'h01;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHide = 2'd1,
        StShow = 2'd2
    } flash_state_e;

    function automatic logic [NUM_LAYERS-1:0] layer_bit(input int idx);
        logic [NUM_LAYERS-1:0] one;
        one = {{(NUM_LAYERS - 1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/layer_select_ctrl_prio_sel_onehot_n.sv
// ----------------------------------------------------------------------------
// prio_sel_onehot_n
// Combinational lowest-index priority encoder with active-low one-hot output.
//   req : per-layer request vector, bit 0 has the highest priority
//   sel : active-low one-hot select of the winning layer, SEL_NONE if req == 0
// ----------------------------------------------------------------------------
module prio_sel_onehot_n
    import layer_select_ctrl_pkg::*;
(
    input  logic [NUM_LAYERS-1:0] req,
    output logic [NUM_LAYERS-1:0] sel
);

    always_comb begin
        sel = SEL_NONE;
        // Scan from the top down so the lowest set index is the final writer.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = ~layer_bit(i);
            end
        end
    end

endmodule

// File: rtl/layer_select_ctrl.sv
// ----------------------------------------------------------------------------
// layer_select_ctrl
// Per-pixel controller for the 7-layer sprite/background output multiplexer.
// Arbitrates among opaque layers, applies a frame-synchronous enable mask and
// a player hit-flash effect, and drives the mux's active-low one-hot select.
//
// Optional feature: define COLLISION_DETECT_EN to record frame-level
// collisions between the player layer and the other layers. Without it the
// collision output is tied to zero.
//
// Parameters:
//   FLASH_FRAMES  : frames a flash sequence lasts (1..255)
// Ports:
//   clk           : pixel-domain clock
//   reset_n       : asynchronous active-low reset
//   pixel_tick    : pixel enable, select updates only on ticks
//   frame_start   : pulse with the tick of the first pixel of a frame
//   layer_req     : bit i set when layer i is opaque at this pixel
//   cfg_valid     : mask update request
//   cfg_ready     : mask update can be accepted
//   cfg_mask      : new layer enable mask (1 = enabled)
//   flash_trigger : start/restart the player flash sequence
//   flashing      : flash sequence active
//   select        : active-low one-hot mux select, SEL_NONE = no layer
//   collision     : previous-frame player collision flags
// ----------------------------------------------------------------------------
module layer_select_ctrl
    import layer_select_ctrl_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pixel_tick,
    input  logic                  frame_start,
    input  logic [NUM_LAYERS-1:0] layer_req,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [NUM_LAYERS-1:0] cfg_mask,
    input  logic                  flash_trigger,
    output logic                  flashing,
    output logic [NUM_LAYERS-1:0] select,
    output logic [NUM_LAYERS-1:0] collision
);

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    // ------------------------------------------------------------------------
    // Mask handshake
    // ------------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] active_mask_q, active_mask_d;
    logic [NUM_LAYERS-1:0] pending_mask_q;
    logic                  pending_valid_q, pending_valid_d;
    logic                  cfg_ready_q;
    logic                  cfg_xfer;
    logic                  mask_apply;

    assign cfg_xfer   = cfg_valid & cfg_ready_q;
    // A transfer in a frame_start cycle finds pending empty, so it waits for
    // the following frame_start.
    assign mask_apply = frame_start & pending_valid_q;

    always_comb begin
        active_mask_d   = active_mask_q;
        pending_valid_d = pending_valid_q;
        if (mask_apply) begin
            active_mask_d   = pending_mask_q;
            pending_valid_d = 1'b0;
        end
        if (cfg_xfer) begin
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_mask_q   <= MASK_ALL;
            pending_mask_q  <= '0;
            pending_valid_q <= 1'b0;
            cfg_ready_q     <= 1'b1;
        end else begin
            active_mask_q   <= active_mask_d;
            pending_valid_q <= pending_valid_d;
            cfg_ready_q     <= ~pending_valid_d;
            if (cfg_xfer) begin
                pending_mask_q <= cfg_mask;
            end
        end
    end

    assign cfg_ready = cfg_ready_q;

    // ------------------------------------------------------------------------
    // Player flash FSM
    // ------------------------------------------------------------------------
    flash_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         flashing_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (flash_trigger) begin
                    state_d = StHide;
                    cnt_d   = FLASH_LOAD;
                end
            end
            StHide, StShow: begin
                // A retrigger only reloads the counter, even on frame_start.
                if (flash_trigger) begin
                    cnt_d = FLASH_LOAD;
                end else if (frame_start) begin
                    if (cnt_q == 8'd1) begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = (state_q == StHide) ? StShow : StHide;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            flashing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flashing_q <= (state_d != StIdle);
        end
    end

    assign flashing = flashing_q;

    // ------------------------------------------------------------------------
    // Pixel arbitration
    // ------------------------------------------------------------------------
    logic                  hide_eff;
    logic [NUM_LAYERS-1:0] eff_mask;
    logic [NUM_LAYERS-1:0] masked_req;
    logic [NUM_LAYERS-1:0] sel_next;
    logic [NUM_LAYERS-1:0] select_q;

    // The first pixel of a frame already sees the post-frame_start mask and
    // flash state; active_mask_d equals active_mask_q outside frame_start.
    assign hide_eff   = frame_start ? (state_d == StHide) : (state_q == StHide);
    assign eff_mask   = active_mask_d & ~(hide_eff ? PLAYER_BIT : '0);
    assign masked_req = layer_req & eff_mask;

    prio_sel_onehot_n u_prio (
        .req (masked_req),
        .sel (sel_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            select_q <= SEL_NONE;
        end else if (pixel_tick) begin
            select_q <= sel_next;
        end
    end

    assign select = select_q;

    // ------------------------------------------------------------------------
    // Collision recording
    // ------------------------------------------------------------------------
`ifdef COLLISION_DETECT_EN
    logic [NUM_LAYERS-1:0] hits;
    logic [NUM_LAYERS-1:0] acc_q;
    logic [NUM_LAYERS-1:0] collision_q;

    // Raw requests: mask and flash do not affect collision detection.
    always_comb begin
        hits = '0;
        for (int i = 1; i < NUM_LAYERS; i++) begin
            hits[i] = layer_req[LAYER_PLAYER] & layer_req[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            collision_q <= '0;
        end else if (frame_start) begin
            collision_q <= acc_q;
            acc_q       <= pixel_tick ? hits : '0;
        end else if (pixel_tick) begin
            acc_q <= acc_q | hits;
        end
    end

    assign collision = collision_q;
`else
    assign collision = '0;
`endif

endmodule

// File: tb/tb_layer_select_ctrl.sv
module tb_layer_select_ctrl;

    localparam int FF = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pixel_tick = 1'b0;
    logic       frame_start = 1'b0;
    logic [6:0] layer_req = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [6:0] cfg_mask = '0;
    logic       flash_trigger = 1'b0;
    logic       flashing;
    logic [6:0] select;
    logic [6:0] collision;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [6:0] m_active, m_pend, m_acc, m_coll;
    bit         m_pend_valid, m_hidden;
    int         m_left;  // frames left in flash sequence, 0 = no flash
    logic [6:0] exp_sel;
    bit         exp_ready, exp_flash;

    layer_select_ctrl #(.FLASH_FRAMES(FF)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pixel_tick    (pixel_tick),
        .frame_start   (frame_start),
        .layer_req     (layer_req),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mask      (cfg_mask),
        .flash_trigger (flash_trigger),
        .flashing      (flashing),
        .select        (select),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 7'h7F; m_pend = '0; m_pend_valid = 0;
        m_hidden = 0; m_left = 0; m_acc = '0; m_coll = '0;
        exp_sel = 7'h7F; exp_ready = 1; exp_flash = 0;
    endtask

    // Drive one clock cycle of inputs and advance the model over the edge.
    task automatic cycle(input bit tick, input bit fs, input logic [6:0] req,
                         input bit cv, input logic [6:0] cm, input bit trig);
        bit         xfer, apply, hide, found;
        logic [6:0] new_mask, cand, one;
        int         new_left;
        bit         new_hidden;
        pixel_tick = tick; frame_start = fs; layer_req = req;
        cfg_valid = cv; cfg_mask = cm; flash_trigger = trig;

        xfer  = cv && exp_ready;
        apply = fs && m_pend_valid;
        new_mask = apply ? m_pend : m_active;
        new_left = m_left; new_hidden = m_hidden;
        if (trig) begin
            if (m_left == 0) new_hidden = 1;
            new_left = FF;
        end else if (fs && m_left != 0) begin
            if (m_left == 1) begin
                new_left = 0; new_hidden = 0;
            end else begin
                new_left = m_left - 1; new_hidden = !m_hidden;
            end
        end
        hide = fs ? new_hidden : m_hidden;
        if (tick) begin
            cand = req & new_mask;
            if (hide) cand[0] = 1'b0;
            exp_sel = 7'h7F; found = 0;
            for (int i = 0; i < 7 && !found; i++) begin
                if (cand[i]) begin
                    one = 7'd1;
                    exp_sel = 7'h7F ^ (one << i);
                    found = 1;
                end
            end
        end
        if (apply) begin m_active = m_pend; m_pend_valid = 0; end
        if (xfer) begin m_pend = cm; m_pend_valid = 1; end
        exp_ready = !m_pend_valid;
        m_left = new_left; m_hidden = new_hidden;
        exp_flash = (m_left != 0);
`ifdef COLLISION_DETECT_EN
        if (fs) begin m_coll = m_acc; m_acc = '0; end
        if (tick && req[0]) m_acc = m_acc | (req & 7'h7E);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        pixel_tick = 0; frame_start = 0; layer_req = '0;
        cfg_valid = 0; cfg_mask = '0; flash_trigger = 0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (select !== 7'h7F) begin miscompares++;
            $display("FAIL reset_select got=%b want=%b", select, 7'h7F); end
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++;
            $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
        vectors++; if (flashing !== 1'b0) begin miscompares++;
            $display("FAIL reset_flashing got=%b want=0", flashing); end
        vectors++; if (collision !== 7'h00) begin miscompares++;
            $display("FAIL reset_collision got=%b want=0", collision); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_select();
        cycle(1, 0, 7'b0010100, 0, '0, 0);
        vectors++; if (select !== 7'b1111011 || select !== exp_sel) begin miscompares++;
            $display("FAIL select_prio got=%b want=%b", select, 7'b1111011); end
        cycle(0, 0, 7'b0000001, 0, '0, 0);
        vectors++; if (select !== 7'b1111011) begin miscompares++;
            $display("FAIL select_hold got=%b want=%b", select, 7'b1111011); end
        cycle(1, 0, 7'b0000000, 0, '0, 0);
        vectors++; if (select !== 7'h7F) begin miscompares++;
            $display("FAIL select_none got=%b want=%b", select, 7'h7F); end
        cycle(1, 0, 7'b1000000, 0, '0, 0);
        vectors++; if (select !== 7'b0111111) begin miscompares++;
            $display("FAIL select_top got=%b want=%b", select, 7'b0111111); end
    endtask

    task automatic test_mask();
        cycle(0, 0, '0, 1, 7'h7B, 0);
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++;
            $display("FAIL mask_ready_low got=%b want=0", cfg_ready); end
        cycle(1, 0, 7'b0000100, 0, '0, 0);
        vectors++; if (select !== 7'b1111011) begin miscompares++;
            $display("FAIL mask_not_yet got=%b want=%b", select, 7'b1111011); end
        vectors++; if (cfg_ready !== 1'b0) begin miscompares++;
            $display("FAIL mask_ready_hold got=%b want=0", cfg_ready); end
        cycle(1, 1, 7'b0000100, 0, '0, 0);
        vectors++; if (select !== 7'h7F) begin miscompares++;
            $display("FAIL mask_applied got=%b want=%b", select, 7'h7F); end
        vectors++; if (cfg_ready !== 1'b1) begin miscompares++;
            $display("FAIL mask_ready_back got=%b want=1", cfg_ready); end
        // Transfer in a frame_start cycle restores the full mask one frame later.
        cycle(1, 1, 7'b0000100, 1, 7'h7F, 0);
        vectors++; if (select !== 7'h7F) begin miscompares++;
            $display("FAIL mask_fs_xfer_late got=%b want=%b", select, 7'h7F); end
        cycle(1, 0, 7'b0000100, 0, '0, 0);
        vectors++; if (select !== 7'h7F) begin miscompares++;
            $display("FAIL mask_fs_xfer_wait got=%b want=%b", select, 7'h7F); end
        cycle(1, 1, 7'b0000100, 0, '0, 0);
        vectors++; if (select !== 7'b1111011) begin miscompares++;
            $display("FAIL mask_fs_xfer_apply got=%b want=%b", select, 7'b1111011); end
    endtask

    task automatic test_flash();
        logic [6:0] want;
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 7'h01, 0, '0, k == 0);
            want = (k < 4 && (k % 2) == 0) ? 7'h7F : 7'h7E;
            vectors++; if (select !== want || select !== exp_sel) begin miscompares++;
                $display("FAIL flash_frame%0d got=%b want=%b", k, select, want); end
            vectors++; if (flashing !== (k < 4)) begin miscompares++;
                $display("FAIL flash_active%0d got=%b want=%b", k, flashing, k < 4); end
            repeat (2) begin
                cycle(1, 0, 7'h01, 0, '0, 0);
                vectors++; if (select !== want) begin miscompares++;
                    $display("FAIL flash_pixel%0d got=%b want=%b", k, select, want); end
            end
        end
    endtask

    task automatic test_reload();
        logic [6:0] want;
        cycle(1, 1, 7'h01, 0, '0, 1);
        repeat (3) cycle(1, 1, 7'h01, 0, '0, 0);
        // Now SHOW with one frame left; retrigger mid-frame.
        cycle(1, 0, 7'h01, 0, '0, 1);
        vectors++; if (select !== 7'h7E || flashing !== 1'b1) begin miscompares++;
            $display("FAIL reload_show got=%b/%b want=%b/1", select, flashing, 7'h7E); end
        for (int j = 0; j < 4; j++) begin
            cycle(1, 1, 7'h01, 0, '0, 0);
            want = (j % 2 == 0) ? 7'h7F : 7'h7E;
            vectors++; if (select !== want || select !== exp_sel) begin miscompares++;
                $display("FAIL reload_frame%0d got=%b want=%b", j, select, want); end
            vectors++; if (flashing !== (j < 3)) begin miscompares++;
                $display("FAIL reload_active%0d got=%b want=%b", j, flashing, j < 3); end
        end
    endtask

    task automatic test_collision();
`ifdef COLLISION_DETECT_EN
        cycle(1, 1, 7'h00, 0, '0, 0);
        cycle(1, 0, 7'b0001001, 0, '0, 0);
        cycle(1, 0, 7'b0000010, 0, '0, 0);
        vectors++; if (collision !== 7'h00) begin miscompares++;
            $display("FAIL coll_before got=%b want=0", collision); end
        cycle(1, 1, 7'h00, 0, '0, 0);
        vectors++; if (collision !== 7'b0001000 || collision !== m_coll) begin miscompares++;
            $display("FAIL coll_report got=%b want=%b", collision, 7'b0001000); end
        cycle(1, 1, 7'h00, 0, '0, 0);
        vectors++; if (collision !== 7'h00) begin miscompares++;
            $display("FAIL coll_clear got=%b want=0", collision); end
`else
        cycle(1, 1, 7'b0001001, 0, '0, 0);
        cycle(1, 1, 7'h00, 0, '0, 0);
        vectors++; if (collision !== 7'h00) begin miscompares++;
            $display("FAIL coll_tied got=%b want=0", collision); end
`endif
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, '0, 0, '0, 1);
        cycle(1, 0, 7'b0000101, 1, 7'h7B, 0);
        vectors++; if (flashing !== 1'b1 || cfg_ready !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_pre got=%b/%b want=1/0", flashing, cfg_ready); end
        apply_reset();
        cycle(1, 1, 7'b0000101, 0, '0, 0);
        vectors++; if (select !== 7'h7E) begin miscompares++;
            $display("FAIL rstmid_player got=%b want=%b", select, 7'h7E); end
        cycle(1, 0, 7'b0000100, 0, '0, 0);
        vectors++; if (select !== 7'b1111011) begin miscompares++;
            $display("FAIL rstmid_discard got=%b want=%b", select, 7'b1111011); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] r;
        for (int i = 0; i < 16; i++) begin
            r = 7'($urandom);
            cycle(1, 0, r, 0, '0, 0);
            vectors++; if (select !== exp_sel) begin miscompares++;
                $display("FAIL b2b_%0d req=%b got=%b want=%b", i, r, select, exp_sel); end
        end
    endtask

    task automatic test_random();
        bit tick, fs, cv, trig;
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(3) != 0);
            fs   = tick && ($urandom_range(15) == 0);
            cv   = ($urandom_range(7) == 0);
            trig = ($urandom_range(39) == 0);
            cycle(tick, fs, 7'($urandom), cv, 7'($urandom), trig);
            vectors++; if (select !== exp_sel) begin miscompares++;
                $display("FAIL rnd_select@%0d got=%b want=%b", i, select, exp_sel); end
            vectors++; if (cfg_ready !== exp_ready) begin miscompares++;
                $display("FAIL rnd_ready@%0d got=%b want=%b", i, cfg_ready, exp_ready); end
            vectors++; if (flashing !== exp_flash) begin miscompares++;
                $display("FAIL rnd_flash@%0d got=%b want=%b", i, flashing, exp_flash); end
            vectors++; if (collision !== m_coll) begin miscompares++;
                $display("FAIL rnd_coll@%0d got=%b want=%b", i, collision, m_coll); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_select();
        test_mask();
        test_flash();
        test_reload();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
